// File: rtl/router_fsm.sv
// router_fsm
// Write-side control FSM for a three-port packet router. It decodes the
// header address, waits for the addressed output FIFO to drain, sequences
// the header, payload and parity writes, and stalls while that FIFO is full.
// Each state drives its own strobe.
//
// Ports
//   clock          rising-edge clock for all state
//   resetn         synchronous, active-low reset
//   pkt_valid      header/payload byte valid; drops with the parity byte
//   data_in[1:0]   destination address taken from the header byte
//   fifo_full      full flag of the currently addressed FIFO
//   fifo_empty_0/1/2   empty flags of output FIFOs 0..2
//   soft_reset_0/1/2   per-port read-timeout resets
//   parity_done    parity byte has been written by the register block
//   low_pkt_valid  pkt_valid fell while the FIFO was full
//   detect_add     header decode strobe (state DA)
//   lfd_state      header write cycle (state LFD)
//   ld_state       payload load cycle (state LD)
//   laf_state      load-after-full cycle (state LAF)
//   full_state     FIFO-full stall (state FFS)
//   write_enb_reg  FIFO write-enable request (LD, LP, LAF)
//   rst_int_reg    parity-check strobe (state CPE)
//   busy           back-pressure to the source
module router_fsm (
   input  logic       clock,
   input  logic       resetn,
   input  logic       pkt_valid,
   input  logic [1:0] data_in,
   input  logic       fifo_full,
   input  logic       fifo_empty_0,
   input  logic       fifo_empty_1,
   input  logic       fifo_empty_2,
   input  logic       soft_reset_0,
   input  logic       soft_reset_1,
   input  logic       soft_reset_2,
   input  logic       parity_done,
   input  logic       low_pkt_valid,
   output logic       detect_add,
   output logic       lfd_state,
   output logic       ld_state,
   output logic       laf_state,
   output logic       full_state,
   output logic       write_enb_reg,
   output logic       rst_int_reg,
   output logic       busy
);

   typedef enum logic [2:0] {
      DA  = 3'd0,
      LFD = 3'd1,
      LD  = 3'd2,
      LP  = 3'd3,
      CPE = 3'd4,
      FFS = 3'd5,
      LAF = 3'd6,
      WTE = 3'd7
   } state_t;

   state_t     state;
   state_t     state_next;
   logic [1:0] addr;
   logic       empty_latched;
   logic       empty_header;
   logic       soft_latched;

   // State and address register. The address is captured on every DA cycle
   // with pkt_valid high, so later states see the port of the current packet.
   always_ff @(posedge clock) begin
      if (!resetn) begin
         state <= DA;
         addr  <= 2'd0;
      end else begin
         state <= state_next;
         if (state == DA && pkt_valid)
            addr <= data_in;
      end
   end

   // Empty flag and soft reset of the latched port. Address 3 selects
   // nothing, so it can never be treated as empty or soft-reset.
   always_comb begin
      empty_latched = 1'b0;
      soft_latched  = 1'b0;
      case (addr)
         2'd0: begin empty_latched = fifo_empty_0; soft_latched = soft_reset_0; end
         2'd1: begin empty_latched = fifo_empty_1; soft_latched = soft_reset_1; end
         2'd2: begin empty_latched = fifo_empty_2; soft_latched = soft_reset_2; end
         default: begin empty_latched = 1'b0; soft_latched = 1'b0; end
      endcase
   end

   // In DA the address has not been registered yet, so the empty flag is
   // selected straight from the header byte.
   always_comb begin
      empty_header = 1'b0;
      case (data_in)
         2'd0: empty_header = fifo_empty_0;
         2'd1: empty_header = fifo_empty_1;
         2'd2: empty_header = fifo_empty_2;
         default: empty_header = 1'b0;
      endcase
   end

   // Next-state logic. A soft reset of the latched port overrides every
   // transition out of a non-DA state.
   always_comb begin
      state_next = state;
      if (state != DA && soft_latched) begin
         state_next = DA;
      end else begin
         case (state)
            DA: begin
               if (pkt_valid && data_in != 2'd3)
                  state_next = empty_header ? LFD : WTE;
            end
            WTE: if (empty_latched) state_next = LFD;
            LFD: state_next = LD;
            LD: begin
               if (fifo_full)
                  state_next = FFS;
               else if (!pkt_valid)
                  state_next = LP;
            end
            FFS: if (!fifo_full) state_next = LAF;
            LAF: begin
               if (parity_done)
                  state_next = DA;
               else if (low_pkt_valid)
                  state_next = LP;
               else
                  state_next = LD;
            end
            LP:  state_next = CPE;
            CPE: state_next = fifo_full ? FFS : DA;
            default: state_next = DA;
         endcase
      end
   end

   // Moore outputs decoded from the current state only.
   always_comb begin
      detect_add    = (state == DA);
      lfd_state     = (state == LFD);
      ld_state      = (state == LD);
      laf_state     = (state == LAF);
      full_state    = (state == FFS);
      rst_int_reg   = (state == CPE);
      write_enb_reg = (state == LD) || (state == LP) || (state == LAF);
      busy          = (state == LFD) || (state == LP) || (state == FFS) ||
                      (state == LAF) || (state == WTE) || (state == CPE);
   end

endmodule

// File: tb/tb_router_fsm.sv
// tb_router_fsm
// Directed bench for router_fsm. Inputs change 1 ns after a rising edge and
// the outputs are sampled 1 ns after the next rising edge. The eight outputs
// are compared as one vector:
// {detect_add, lfd_state, ld_state, laf_state, full_state, write_enb_reg,
//  rst_int_reg, busy}
module tb_router_fsm;

   logic       clock;
   logic       resetn;
   logic       pkt_valid;
   logic [1:0] data_in;
   logic       fifo_full;
   logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
   logic       soft_reset_0, soft_reset_1, soft_reset_2;
   logic       parity_done;
   logic       low_pkt_valid;
   logic       detect_add, lfd_state, ld_state, laf_state, full_state;
   logic       write_enb_reg, rst_int_reg, busy;

   int passCount  = 0;
   int checkCount = 0;

   // Expected output vector for each state, written out by hand
   localparam logic [7:0] EXP_DA  = 8'b1000_0000;
   localparam logic [7:0] EXP_LFD = 8'b0100_0001;
   localparam logic [7:0] EXP_LD  = 8'b0010_0100;
   localparam logic [7:0] EXP_LAF = 8'b0001_0101;
   localparam logic [7:0] EXP_FFS = 8'b0000_1001;
   localparam logic [7:0] EXP_LP  = 8'b0000_0101;
   localparam logic [7:0] EXP_CPE = 8'b0000_0011;
   localparam logic [7:0] EXP_WTE = 8'b0000_0001;

   router_fsm dut (
      .clock        (clock),
      .resetn       (resetn),
      .pkt_valid    (pkt_valid),
      .data_in      (data_in),
      .fifo_full    (fifo_full),
      .fifo_empty_0 (fifo_empty_0),
      .fifo_empty_1 (fifo_empty_1),
      .fifo_empty_2 (fifo_empty_2),
      .soft_reset_0 (soft_reset_0),
      .soft_reset_1 (soft_reset_1),
      .soft_reset_2 (soft_reset_2),
      .parity_done  (parity_done),
      .low_pkt_valid(low_pkt_valid),
      .detect_add   (detect_add),
      .lfd_state    (lfd_state),
      .ld_state     (ld_state),
      .laf_state    (laf_state),
      .full_state   (full_state),
      .write_enb_reg(write_enb_reg),
      .rst_int_reg  (rst_int_reg),
      .busy         (busy)
   );

   // 10 ns clock
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Compare one observed value with its expected value and count it
   task automatic checkOutput(input string tag, input logic [7:0] observed,
                              input logic [7:0] expected);
      checkCount++;
      if (observed === expected)
         passCount++;
      else
         $display("[TB] FAIL %s: got %b, expected %b", tag, observed, expected);
   endtask

   // Advance one clock and leave time 1 ns past the edge
   task automatic applyStimulus();
      @(posedge clock);
      #1;
   endtask

   function automatic logic [7:0] outVec();
      return {detect_add, lfd_state, ld_state, laf_state, full_state,
              write_enb_reg, rst_int_reg, busy};
   endfunction

   // Clock once, then compare the outputs with the expected state vector
   task automatic stepCheck(input string tag, input logic [7:0] expected);
      applyStimulus();
      checkOutput(tag, outVec(), expected);
   endtask

   initial begin
      resetn        = 1'b0;
      pkt_valid     = 1'b0;
      data_in       = 2'd0;
      fifo_full     = 1'b0;
      fifo_empty_0  = 1'b1;
      fifo_empty_1  = 1'b1;
      fifo_empty_2  = 1'b1;
      soft_reset_0  = 1'b0;
      soft_reset_1  = 1'b0;
      soft_reset_2  = 1'b0;
      parity_done   = 1'b0;
      low_pkt_valid = 1'b0;

      // Reset state
      stepCheck("reset_da", EXP_DA);
      stepCheck("reset_hold", EXP_DA);
      resetn = 1'b1;
      stepCheck("idle_da", EXP_DA);

      // Normal packet to port 1 with three payload cycles
      pkt_valid = 1'b1; data_in = 2'd1; fifo_empty_1 = 1'b1;
      stepCheck("norm_lfd", EXP_LFD);
      stepCheck("norm_ld1", EXP_LD);
      stepCheck("norm_ld2", EXP_LD);
      stepCheck("norm_ld3", EXP_LD);
      pkt_valid = 1'b0;
      stepCheck("norm_lp", EXP_LP);
      stepCheck("norm_cpe", EXP_CPE);
      stepCheck("norm_da", EXP_DA);

      // Port 2 busy for five cycles; port 0 empty must not matter once latched
      pkt_valid = 1'b1; data_in = 2'd2; fifo_empty_2 = 1'b0;
      stepCheck("wte_1", EXP_WTE);
      pkt_valid = 1'b0; data_in = 2'd0; fifo_empty_0 = 1'b1;
      for (int i = 2; i <= 5; i++)
         stepCheck($sformatf("wte_%0d", i), EXP_WTE);
      fifo_empty_2 = 1'b1; pkt_valid = 1'b1;
      stepCheck("wte_lfd", EXP_LFD);
      stepCheck("full_ld", EXP_LD);

      // Full mid-payload; fifo_full wins over pkt_valid low
      fifo_full = 1'b1; pkt_valid = 1'b0;
      stepCheck("full_ffs", EXP_FFS);
      stepCheck("full_ffs_hold", EXP_FFS);
      fifo_full = 1'b0; parity_done = 1'b0; low_pkt_valid = 1'b1;
      stepCheck("full_laf", EXP_LAF);
      stepCheck("laf_lp", EXP_LP);
      low_pkt_valid = 1'b0; fifo_full = 1'b1;
      stepCheck("lp_cpe", EXP_CPE);
      stepCheck("cpe_ffs", EXP_FFS);
      fifo_full = 1'b0; parity_done = 1'b1;
      stepCheck("full_laf2", EXP_LAF);
      stepCheck("laf_da", EXP_DA);
      parity_done = 1'b0;

      // LAF falls back to LD when neither parity_done nor low_pkt_valid
      pkt_valid = 1'b1; data_in = 2'd1;
      stepCheck("laf2_lfd", EXP_LFD);
      stepCheck("laf2_ld", EXP_LD);
      fifo_full = 1'b1;
      stepCheck("laf2_ffs", EXP_FFS);
      fifo_full = 1'b0;
      stepCheck("laf2_laf", EXP_LAF);
      stepCheck("laf_ld", EXP_LD);
      pkt_valid = 1'b0;
      stepCheck("laf2_lp", EXP_LP);
      stepCheck("laf2_cpe", EXP_CPE);
      stepCheck("laf2_da", EXP_DA);

      // Soft reset in WTE: other port ignored, latched port forces DA
      pkt_valid = 1'b1; data_in = 2'd0; fifo_empty_0 = 1'b0;
      stepCheck("soft_wte", EXP_WTE);
      pkt_valid = 1'b0; soft_reset_1 = 1'b1;
      stepCheck("soft_other", EXP_WTE);
      soft_reset_1 = 1'b0; soft_reset_0 = 1'b1;
      stepCheck("soft_wte_da", EXP_DA);
      soft_reset_0 = 1'b0;

      // Soft reset in FFS for port 0
      pkt_valid = 1'b1; data_in = 2'd0; fifo_empty_0 = 1'b1;
      stepCheck("soft2_lfd", EXP_LFD);
      stepCheck("soft2_ld", EXP_LD);
      fifo_full = 1'b1;
      stepCheck("soft2_ffs", EXP_FFS);
      soft_reset_0 = 1'b1;
      stepCheck("soft_ffs_da", EXP_DA);
      soft_reset_0 = 1'b0; fifo_full = 1'b0; pkt_valid = 1'b0;
      stepCheck("soft2_idle", EXP_DA);

      // Reset in the middle of a packet
      pkt_valid = 1'b1; data_in = 2'd1;
      stepCheck("rst_lfd", EXP_LFD);
      stepCheck("rst_ld", EXP_LD);
      resetn = 1'b0;
      stepCheck("rst_mid_da", EXP_DA);
      resetn = 1'b1;

      // Address 3 never leaves DA
      pkt_valid = 1'b1; data_in = 2'd3;
      stepCheck("addr3_da1", EXP_DA);
      stepCheck("addr3_da2", EXP_DA);
      pkt_valid = 1'b0;

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
